vga_fb_display: RTL and testbench

- Downstream consumer of the CPU's memory-mapped I/O writes.
- Holds an 80x60-cell colour framebuffer that the CPU writes through the I/O decode in the top level.
- Continuously scans the framebuffer out as a 640x480@60 Hz VGA signal: each cell is 8x8 pixels, 3-bit RGB.
- Runs on the 50 MHz board clock with an internal 25 MHz pixel enable.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing.sv | 77 +++++++
 rtl/vga_fb_display.sv | 131 +++++++++++++
 tb/tb_vga_fb_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and the cell-address helper.
package vga_pkg;

    localparam int unsigned H_VIS      = 640;
    localparam int unsigned H_FP       = 16;
    localparam int unsigned H_SYNC     = 96;
    localparam int unsigned H_BP       = 48;
    localparam int unsigned H_TOTAL    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned HS_START   = H_VIS + H_FP;
    localparam int unsigned HS_END     = HS_START + H_SYNC - 1;

    localparam int unsigned V_VIS      = 480;
    localparam int unsigned V_FP       = 10;
    localparam int unsigned V_SYNC     = 2;
    localparam int unsigned V_BP       = 33;
    localparam int unsigned V_TOTAL    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned VS_START   = V_VIS + V_FP;
    localparam int unsigned VS_END     = VS_START + V_SYNC - 1;

    localparam int unsigned CELL_SHIFT = 3;
    localparam int unsigned FB_COLS    = 80;
    localparam int unsigned FB_ROWS    = 60;
    localparam int unsigned FB_DEPTH   = FB_COLS * FB_ROWS;

    localparam int unsigned CNT_W      = 10;
    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned CH_W       = 8;

    typedef logic [2:0] rgb3_t;

    // row*80 + col built from two shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] h,
                                                    input logic [CNT_W-1:0] v);
        logic [ADDR_W-1:0] row;
        row = ADDR_W'(v >> CELL_SHIFT);
        return (row << 6) + (row << 4) + ADDR_W'(h >> CELL_SHIFT);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable generator, scan counters and sync/visible decode for the VGA raster.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned HVIS  = H_VIS,
    parameter int unsigned HFP   = H_FP,
    parameter int unsigned HSYNC = H_SYNC,
    parameter int unsigned HBP   = H_BP,
    parameter int unsigned VVIS  = V_VIS,
    parameter int unsigned VFP   = V_FP,
    parameter int unsigned VSYNC = V_SYNC,
    parameter int unsigned VBP   = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             phase,
    output logic             pix_en_c,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hs_c,
    output logic             vs_c,
    output logic             visible_c,
    output logic             vblank,
    output logic             frame_tick
);

    localparam int unsigned HTOT    = HVIS + HFP + HSYNC + HBP;
    localparam int unsigned VTOT    = VVIS + VFP + VSYNC + VBP;
    localparam int unsigned HS_BEG  = HVIS + HFP;
    localparam int unsigned HS_LAST = HS_BEG + HSYNC - 1;
    localparam int unsigned VS_BEG  = VVIS + VFP;
    localparam int unsigned VS_LAST = VS_BEG + VSYNC - 1;

    logic             h_last_c;
    logic             v_last_c;
    logic [CNT_W-1:0] h_next_c;
    logic [CNT_W-1:0] v_next_c;

    assign pix_en_c = phase;

    // Next raster position; vertical advances only on the horizontal wrap
    always_comb begin
        h_last_c = (hcnt == CNT_W'(HTOT - 1));
        v_last_c = (vcnt == CNT_W'(VTOT - 1));
        h_next_c = hcnt + CNT_W'(1);
        v_next_c = vcnt;
        if (h_last_c) begin
            h_next_c = '0;
            v_next_c = v_last_c ? '0 : vcnt + CNT_W'(1);
        end
    end

    always_comb begin
        hs_c      = (hcnt >= CNT_W'(HS_BEG)) && (hcnt <= CNT_W'(HS_LAST));
        vs_c      = (vcnt >= CNT_W'(VS_BEG)) && (vcnt <= CNT_W'(VS_LAST));
        visible_c = (hcnt < CNT_W'(HVIS)) && (vcnt < CNT_W'(VVIS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            vblank     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            phase      <= ~phase;
            frame_tick <= pix_en_c && h_last_c && v_last_c;
            if (pix_en_c) begin
                hcnt   <= h_next_c;
                vcnt   <= v_next_c;
                vblank <= (v_next_c >= CNT_W'(VVIS));
            end
        end
    end

endmodule

// File: rtl/vga_fb_display.sv
// 80x60-cell colour framebuffer scanned out as VGA through a 3-stage pixel pipeline.
module vga_fb_display
    import vga_pkg::*;
#(
    parameter int unsigned HVIS  = H_VIS,
    parameter int unsigned HFP   = H_FP,
    parameter int unsigned HSYNC = H_SYNC,
    parameter int unsigned HBP   = H_BP,
    parameter int unsigned VVIS  = V_VIS,
    parameter int unsigned VFP   = V_FP,
    parameter int unsigned VSYNC = V_SYNC,
    parameter int unsigned VBP   = V_BP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [2:0]        wdata,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B,
    output logic              vblank,
    output logic              frame_tick
);

    logic              pix_en_c;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic              hs_c;
    logic              vs_c;
    logic              visible_c;

    logic [ADDR_W-1:0] rd_addr;
    logic              s1_hs;
    logic              s1_vs;
    logic              s1_vis;
    rgb3_t             rd_data;
    logic              s2_hs;
    logic              s2_vs;
    logic              s2_vis;

    rgb3_t             fb_mem [FB_DEPTH];

    vga_timing #(
        .HVIS  (HVIS),
        .HFP   (HFP),
        .HSYNC (HSYNC),
        .HBP   (HBP),
        .VVIS  (VVIS),
        .VFP   (VFP),
        .VSYNC (VSYNC),
        .VBP   (VBP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (reset),
        .phase      (VGA_CLK),
        .pix_en_c   (pix_en_c),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hs_c       (hs_c),
        .vs_c       (vs_c),
        .visible_c  (visible_c),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    assign VGA_SYNC_N = 1'b0;

    // Block RAM: unreset, read-first on a same-address collision
    always_ff @(posedge clk) begin
        if (we && (waddr < ADDR_W'(FB_DEPTH))) begin
            fb_mem[waddr] <= wdata;
        end
        if (pix_en_c) begin
            rd_data <= fb_mem[rd_addr];
        end
    end

    // S1: cell address (parked at 0 outside the visible area) and raw timing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr <= '0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_vis  <= 1'b0;
        end else if (pix_en_c) begin
            rd_addr <= visible_c ? cell_addr(hcnt, vcnt) : '0;
            s1_hs   <= hs_c;
            s1_vs   <= vs_c;
            s1_vis  <= visible_c;
        end
    end

    // S2: timing delayed to line up with the RAM read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_vis <= 1'b0;
        end else if (pix_en_c) begin
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_vis <= s1_vis;
        end
    end

    // S3: output pins, colour expanded to 8 bits and forced black when blanked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en_c) begin
            VGA_HS      <= ~s2_hs;
            VGA_VS      <= ~s2_vs;
            VGA_BLANK_N <= s2_vis;
            VGA_R       <= s2_vis ? {CH_W{rd_data[2]}} : '0;
            VGA_G       <= s2_vis ? {CH_W{rd_data[1]}} : '0;
            VGA_B       <= s2_vis ? {CH_W{rd_data[0]}} : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_display.sv
// Self-checking bench: reduced raster geometry, raster-position model, table and corner sequences.
module tb_vga_fb_display;

    localparam int HVIS = 64, HFP = 4, HSYNC = 8, HBP = 4;
    localparam int VVIS = 24, VFP = 2, VSYNC = 2, VBP = 3;
    localparam int HT = HVIS + HFP + HSYNC + HBP;
    localparam int VT = VVIS + VFP + VSYNC + VBP;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [12:0] waddr = '0;
    logic [2:0]  wdata = '0;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        vblank, frame_tick;

    vga_fb_display #(
        .HVIS(HVIS), .HFP(HFP), .HSYNC(HSYNC), .HBP(HBP),
        .VVIS(VVIS), .VFP(VFP), .VSYNC(VSYNC), .VBP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .vblank(vblank), .frame_tick(frame_tick)
    );

    always #10 clk = ~clk;

    // clk edges since the last reset release
    int edge_n;
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    int checks = 0;
    int errors = 0;

    typedef struct { int e; int a; logic [2:0] d; } wr_t;
    wr_t        wq[$];
    logic [2:0] fb_model [0:4799];

    typedef struct {
        int          a;
        logic [2:0]  d;
        int          x;
        int          y;
        logic [23:0] rgb;
        logic        blank_n;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expected pins from the raster position: pins after pixel tick k show position k-3
    task automatic monitor();
        int k, p, x, y, rd_edge;
        logic [2:0] col;
        logic hs_n, vs_n, bl, vb, ft;
        logic [30:0] exp_v, act_v;
        wr_t w;
        k = edge_n / 2;
        rd_edge = 2 * k - 2;
        while (wq.size() > 0 && (!reset || wq[0].e < rd_edge)) begin
            w = wq.pop_front();
            if (w.a < 4800) fb_model[w.a] = w.d;
        end
        hs_n = 1'b1; vs_n = 1'b1; bl = 1'b0; col = 3'b000;
        if (k >= 3) begin
            p = k - 3;
            x = p % HT;
            y = (p / HT) % VT;
            bl   = (x < HVIS) && (y < VVIS);
            hs_n = !((x >= HVIS + HFP) && (x < HVIS + HFP + HSYNC));
            vs_n = !((y >= VVIS + VFP) && (y < VVIS + VFP + VSYNC));
            if (bl) col = fb_model[(y / 8) * 80 + x / 8];
        end
        vb = (((k / HT) % VT) >= VVIS);
        ft = (edge_n % 2 == 0) && (k > 0) && (k % FR == 0);
        exp_v = {(edge_n % 2 == 1), hs_n, vs_n, bl, {8{col[2]}}, {8{col[1]}}, {8{col[0]}}, vb, ft, 1'b0};
        act_v = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, vblank, frame_tick, VGA_SYNC_N};
        check("scan_pins", 32'(act_v), 32'(exp_v));
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic drive_write(input int a, input logic [2:0] d);
        wr_t w;
        we = 1'b1;
        waddr = 13'(a);
        wdata = d;
        w.e = edge_n + 1;
        w.a = a;
        w.d = d;
        wq.push_back(w);
        step();
    endtask

    task automatic wait_pixel(input int x, input int y);
        int kc, kt;
        kc = edge_n / 2;
        kt = kc - (kc % FR) + y * HT + x + 3;
        if (2 * kt <= edge_n) kt += FR;
        while (edge_n < 2 * kt) step();
    endtask

    // sel: 0 BLANK_N, 1 HS, 2 VS, 3 frame_tick; at = -1 on timeout
    task automatic wait_for(input int sel, input logic val, input int budget, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            case (sel)
                0:       s = VGA_BLANK_N;
                1:       s = VGA_HS;
                2:       s = VGA_VS;
                default: s = frame_tick;
            endcase
            if (s === val) begin
                at = edge_n;
                break;
            end
        end
    endtask

    initial begin
        int at, t, kc, base;

        tbl[0] = '{0,    3'b100, 0,  0,  24'hFF0000, 1'b1};
        tbl[1] = '{4799, 3'b011, 7,  0,  24'hFF0000, 1'b1};
        tbl[2] = '{1,    3'b001, 8,  0,  24'h0000FF, 1'b1};
        tbl[3] = '{8191, 3'b111, 64, 0,  24'h000000, 1'b0};
        tbl[4] = '{4800, 3'b111, 7,  7,  24'hFF0000, 1'b1};
        tbl[5] = '{80,   3'b010, 0,  8,  24'h00FF00, 1'b1};
        tbl[6] = '{81,   3'b111, 15, 15, 24'hFFFFFF, 1'b1};
        tbl[7] = '{167,  3'b011, 63, 23, 24'h00FFFF, 1'b1};

        for (int i = 0; i < 4800; i++) fb_model[i] = 3'b000;

        // Clear the visible cells while reset is held
        step();
        check("reset_state", 32'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B, frame_tick, vblank}),
              32'({1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0}));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++) drive_write(r * 80 + c, 3'b000);
        we = 1'b0;
        step();
        reset = 1'b1;

        // Sync timing and latency from a fresh release
        wait_for(0, 1'b1, 100, at);
        check("blank_first_rise", 32'(at), 32'(6));
        wait_for(1, 1'b0, 4 * HT, at);
        check("hs_fall_after_blank", 32'(at), 32'(6 + 2 * (HVIS + HFP)));
        t = at;
        wait_for(1, 1'b1, 4 * HT, at);
        check("hs_low_width", 32'(at - t), 32'(2 * HSYNC));
        wait_for(1, 1'b0, 4 * HT, at);
        check("hs_period", 32'(at - t), 32'(2 * HT));
        wait_for(2, 1'b0, 4 * FR, at);
        check("vs_first_fall", 32'(at), 32'(2 * ((VVIS + VFP) * HT + 3)));
        t = at;
        wait_for(2, 1'b1, 4 * FR, at);
        check("vs_low_width", 32'(at - t), 32'(2 * VSYNC * HT));
        wait_for(3, 1'b1, 4 * FR, at);
        check("frame_tick_first", 32'(at), 32'(2 * FR));
        t = at;
        wait_for(3, 1'b0, 4, at);
        check("frame_tick_width", 32'(at - t), 32'(1));
        wait_for(3, 1'b1, 4 * FR, at);
        check("frame_tick_period", 32'(at - t), 32'(2 * FR));

        // Cell mapping and out-of-range writes: back-to-back writes, then pixel probes
        for (int i = 0; i < 8; i++) drive_write(tbl[i].a, tbl[i].d);
        we = 1'b0;
        wait_pixel(0, VVIS);
        for (int i = 0; i < 8; i++) begin
            wait_pixel(tbl[i].x, tbl[i].y);
            check($sformatf("cell_rgb_%0d", i), 32'({VGA_R, VGA_G, VGA_B}), 32'(tbl[i].rgb));
            check($sformatf("cell_blank_%0d", i), 32'(VGA_BLANK_N), 32'(tbl[i].blank_n));
        end

        // Read/write collision on cell 0: write lands on the edge S2 reads pixel (0,0)
        kc = edge_n / 2;
        base = (kc / FR + 1) * FR;
        while (edge_n < 2 * base + 3) step();
        drive_write(0, 3'b010);
        we = 1'b0;
        while (edge_n < 2 * base + 6) step();
        check("collision_old", 32'({VGA_R, VGA_G, VGA_B}), 32'(24'hFF0000));
        wait_pixel(0, 0);
        check("collision_next_frame", 32'({VGA_R, VGA_G, VGA_B}), 32'(24'h00FF00));

        // Random writes, some back-to-back, scored by the raster model
        for (int i = 0; i < 500; i++) begin
            int n_idle, burst, a;
            n_idle = $urandom_range(0, 20);
            for (int j = 0; j < n_idle; j++) step();
            burst = $urandom_range(1, 3);
            for (int j = 0; j < burst; j++) begin
                if ($urandom_range(0, 3) != 0) a = $urandom_range(0, 2) * 80 + $urandom_range(0, 7);
                else a = $urandom_range(0, 8191);
                drive_write(a, 3'($urandom_range(0, 7)));
            end
            we = 1'b0;
        end
        wait_pixel(0, VVIS);
        wait_pixel(0, VVIS);

        // Mid-frame reset with the vertical counter at line 10
        wait_pixel(17, 10);
        #5 reset = 1'b0;
        #1;
        check("midrst_sync", 32'({VGA_HS, VGA_VS, VGA_BLANK_N}), 32'(3'b110));
        check("midrst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(0));
        check("midrst_misc", 32'({VGA_CLK, frame_tick, vblank}), 32'(0));
        step();
        step();
        reset = 1'b1;
        wait_for(2, 1'b0, 4 * FR, at);
        check("vs_after_midrst", 32'(at), 32'(2 * ((VVIS + VFP) * HT + 3)));
        wait_for(0, 1'b1, 4 * FR, at);
        check("blank_after_midrst", 32'(at % (2 * FR)), 32'(6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
